vector_seq: RTL and testbench

Image sequencer for the vector display path: walks a point ROM from a given start address, decodes each 18-bit entry as move / draw / end, and emits a beam-position stream toward the DAC driver. Draw entries are rasterised with Bresenham stepping, so every intermediate beam point is produced. It is the reader side of the image ROMs; its output stream feeds the X/Y DAC and blanking logic.

---
 rtl/vector_seq.sv | 156 +++++++++++++++
 tb/tb_vector_seq.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_seq.sv
// Vector display image sequencer: walks a point ROM, decodes move/draw/end entries
// and emits a Bresenham-rasterised beam-position stream with a valid/ready handshake.
module vector_seq #(
    parameter int ADDRESSWIDTH  = 16,
    parameter int DATAWIDTH     = 18,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDRESSWIDTH-1:0] start_addr,
    output logic [ADDRESSWIDTH-1:0] rom_addr,
    input  logic [DATAWIDTH-1:0]    rom_data,
    output logic [7:0]              x_out,
    output logic [7:0]              y_out,
    output logic                    beam_on,
    output logic                    pt_valid,
    input  logic                    pt_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, MOVE, SETTLE, DRAW} state_t;
    state_t state;

    logic [7:0]         cx, cy, tx, ty;
    logic signed [10:0] berr, bdx, bdy;
    logic               bsx, bsy;
    logic [CW-1:0]      cnt;

    logic [7:0]         fx, fy;
    logic [1:0]         kind;
    logic signed [10:0] ddx, ddy, adx, ady;
    assign fx   = rom_data[17:10];
    assign fy   = rom_data[9:2];
    assign kind = rom_data[1:0];
    assign ddx  = $signed({3'b000, fx}) - $signed({3'b000, cx});
    assign ddy  = $signed({3'b000, fy}) - $signed({3'b000, cy});
    assign adx  = ddx[10] ? -ddx : ddx;
    assign ady  = ddy[10] ? -ddy : ddy;

    // One Bresenham step; in FETCH it is seeded from the freshly decoded entry so the
    // first stepped point can be presented the cycle after the fetch.
    logic [7:0]         px, py, nx, ny;
    logic signed [10:0] pe, pdx, pdy, ne;
    logic signed [11:0] e2, pdx12, pdy12;
    logic               psx, psy, stepx, stepy;
    always_comb begin
        if (state == FETCH) begin
            px = cx;  py = cy;  pe = adx - ady;
            pdx = adx;  pdy = -ady;  psx = ~ddx[10];  psy = ~ddy[10];
        end else begin
            px = x_out;  py = y_out;  pe = berr;
            pdx = bdx;  pdy = bdy;  psx = bsx;  psy = bsy;
        end
        e2    = {pe, 1'b0};
        pdx12 = {pdx[10], pdx};
        pdy12 = {pdy[10], pdy};
        stepx = (e2 >= pdy12);
        stepy = (e2 <= pdx12);
        nx    = stepx ? (psx ? px + 8'd1 : px - 8'd1) : px;
        ny    = stepy ? (psy ? py + 8'd1 : py - 8'd1) : py;
        ne    = pe + (stepx ? pdy : 11'sd0) + (stepy ? pdx : 11'sd0);
    end

    logic hs, at_tgt, adv;
    assign hs     = pt_valid && pt_ready;
    assign at_tgt = (x_out == tx) && (y_out == ty);
    assign adv    = ((state == SETTLE) && (cnt == '0)) ||
                    ((state == MOVE) && hs && (SETTLE_CYCLES == 0)) ||
                    ((state == DRAW) && hs && at_tgt);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            rom_addr <= '0;
            x_out    <= '0;
            y_out    <= '0;
            beam_on  <= 1'b0;
            pt_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            cx       <= '0;
            cy       <= '0;
            tx       <= '0;
            ty       <= '0;
            berr     <= '0;
            bdx      <= '0;
            bdy      <= '0;
            bsx      <= 1'b0;
            bsy      <= 1'b0;
            cnt      <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: if (start && !done) begin
                    rom_addr <= start_addr;
                    busy     <= 1'b1;
                    state    <= FETCH;
                end
                FETCH: begin
                    tx <= fx;
                    ty <= fy;
                    case (kind)
                        2'b01: begin
                            x_out <= fx;  y_out <= fy;
                            beam_on <= 1'b0;  pt_valid <= 1'b1;  state <= MOVE;
                        end
                        2'b10: begin
                            beam_on <= 1'b1;  pt_valid <= 1'b1;  state <= DRAW;
                            bdx <= adx;  bdy <= -ady;  bsx <= ~ddx[10];  bsy <= ~ddy[10];
                            if (fx == cx && fy == cy) begin
                                x_out <= fx;  y_out <= fy;
                            end else begin
                                x_out <= nx;  y_out <= ny;  berr <= ne;
                            end
                        end
                        2'b11: begin
                            done <= 1'b1;  busy <= 1'b0;  state <= IDLE;
                        end
                        default: begin
                            done <= 1'b1;  err <= 1'b1;  busy <= 1'b0;  state <= IDLE;
                        end
                    endcase
                end
                MOVE: if (hs) begin
                    cx <= tx;  cy <= ty;  pt_valid <= 1'b0;
                    state <= SETTLE;
                    cnt   <= CW'(SETTLE_CYCLES - 1);
                end
                SETTLE: if (cnt != '0) cnt <= cnt - 1'b1;
                DRAW: if (hs) begin
                    if (at_tgt) begin
                        cx <= tx;  cy <= ty;  pt_valid <= 1'b0;
                    end else begin
                        x_out <= nx;  y_out <= ny;  berr <= ne;
                    end
                end
                default: state <= IDLE;
            endcase
            // Entry finished: step to the next one, or stop at the top of the ROM.
            if (adv) begin
                if (&rom_addr) begin
                    done <= 1'b1;  err <= 1'b1;  busy <= 1'b0;  state <= IDLE;
                end else begin
                    rom_addr <= rom_addr + 1'b1;
                    state    <= FETCH;
                end
            end
        end
    end
endmodule

// File: tb/tb_vector_seq.sv
// Self-checking bench for vector_seq: ROM model, point-stream scoreboard against a
// line-drawing reference model, plus latency and handshake corner checks.
`timescale 1ns/1ps
module tb_vector_seq;
    typedef logic [16:0] pt_t;  // {beam_on, x, y}

    logic        clk, rst_n, start, pt_ready, beam_on, pt_valid, busy, done, err;
    logic [15:0] start_addr, rom_addr;
    logic [17:0] rom_data;
    logic [7:0]  x_out, y_out;
    logic [17:0] rom [0:65535];

    assign rom_data = rom[rom_addr];

    vector_seq #(.ADDRESSWIDTH(16), .DATAWIDTH(18), .SETTLE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .rom_addr(rom_addr), .rom_data(rom_data), .x_out(x_out), .y_out(y_out),
        .beam_on(beam_on), .pt_valid(pt_valid), .pt_ready(pt_ready),
        .busy(busy), .done(done), .err(err)
    );

    int   tests = 0, fails = 0, cyc = 0;
    int   start_cyc, fetch_cyc, watch_addr, done_cnt;
    int   mx = 0, my = 0;
    bit   bp_mode = 0, prev_stall = 0, exp_err;
    pt_t  prev_pt;
    pt_t  got[$], exp_q[$], diag_q[$];
    int   got_cyc[$];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        pt_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2 pt_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Transfer recorder and stall-stability check.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    tests++;
                    if (pt_valid !== 1'b1 || {beam_on, x_out, y_out} !== prev_pt) begin
                        fails++;
                        $display("FAIL stall_hold: got v=%b pt=%h, required v=1 pt=%h", pt_valid, {beam_on, x_out, y_out}, prev_pt);
                    end
                end
                if (pt_valid && pt_ready) begin
                    got.push_back({beam_on, x_out, y_out});
                    got_cyc.push_back(cyc);
                end
                prev_stall = pt_valid && !pt_ready;
                prev_pt    = {beam_on, x_out, y_out};
                if (done) done_cnt++;
                if (busy && int'(rom_addr) == watch_addr && fetch_cyc < 0) fetch_cyc = cyc;
            end
        end
    end

    function automatic logic [17:0] ent(input int x, input int y, input int t);
        logic [17:0] w;
        w = {x[7:0], y[7:0], t[1:0]};
        return w;
    endfunction

    // Reference: walk the ROM image, drawing lines with the textbook integer algorithm.
    task automatic model_run(input int sa);
        int a, k, x0, y0, x1, y1, dx, dy, sx, sy, er, e2;
        logic [17:0] w;
        exp_q.delete();
        a = sa;
        while (1) begin
            w = rom[a];  k = int'(w[1:0]);  x1 = int'(w[17:10]);  y1 = int'(w[9:2]);
            if (k == 3) begin exp_err = 0; break; end
            if (k == 0) begin exp_err = 1; break; end
            if (k == 1) begin
                exp_q.push_back({1'b0, x1[7:0], y1[7:0]});
            end else if (x1 == mx && y1 == my) begin
                exp_q.push_back({1'b1, x1[7:0], y1[7:0]});
            end else begin
                x0 = mx;  y0 = my;
                dx = (x1 > x0) ? x1 - x0 : x0 - x1;
                dy = (y1 > y0) ? y0 - y1 : y1 - y0;
                sx = (x1 > x0) ? 1 : -1;
                sy = (y1 > y0) ? 1 : -1;
                er = dx + dy;
                while (!(x0 == x1 && y0 == y1)) begin
                    e2 = 2 * er;
                    if (e2 >= dy) begin er += dy; x0 += sx; end
                    if (e2 <= dx) begin er += dx; y0 += sy; end
                    exp_q.push_back({1'b1, x0[7:0], y0[7:0]});
                end
            end
            mx = x1;  my = y1;
            if (a == 65535) begin exp_err = 1; break; end
            a++;
        end
    endtask

    task automatic pulse_start(input int sa, input bit clr);
        @(negedge clk);
        start = 1'b1;  start_addr = 16'(sa);
        if (clr) begin
            start_cyc = cyc;  got.delete();  got_cyc.delete();  done_cnt = 0;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        bit ok = 0;
        dcyc = -1;
        for (int i = 0; i < budget; i++) begin
            if (done) begin ok = 1; dcyc = cyc; break; end
            @(negedge clk);
        end
        if (!ok) begin
            tests++;  fails++;
            $display("FAIL done_timeout: no done within %0d cycles, required a done pulse", budget);
        end
    endtask

    task automatic check_run(input string name);
        int bad = 0, first = -1;
        tests++;
        if (got.size() != exp_q.size()) begin
            fails++;
            $display("FAIL %s_count: got %0d points, required %0d", name, got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            if (got[i] !== exp_q[i]) begin bad++; if (first < 0) first = i; end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL %s_points: %0d wrong, first at %0d got %h required %h", name, bad, first, got[first], exp_q[first]);
        end
        tests++;
        if (err !== exp_err) begin
            fails++;
            $display("FAIL %s_err: got %b, required %b", name, err, exp_err);
        end
    endtask

    task automatic run_image(input int sa, input string name);
        int d;
        model_run(sa);
        pulse_start(sa, 1);
        wait_done(20000, d);
        check_run(name);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        tests++;
        if ({rom_addr, x_out, y_out, beam_on, pt_valid, busy, done, err} !== '0) begin
            fails++;
            $display("FAIL reset_state: got %h, required 0", {rom_addr, x_out, y_out, beam_on, pt_valid, busy, done, err});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_frame;
        rom[0] = ent(0, 254, 1);  rom[1] = ent(0, 0, 2);  rom[2] = ent(254, 0, 2);
        rom[3] = ent(254, 254, 2);  rom[4] = ent(0, 254, 2);  rom[5] = ent(0, 0, 3);
        run_image(0, "frame");
        tests++;
        if (got.size() != 1017 || got[0] !== {1'b0, 8'd0, 8'd254} || got[$] !== {1'b1, 8'd0, 8'd254}) begin
            fails++;
            $display("FAIL frame_shape: got n=%0d first=%h last=%h, required n=1017 first=000fe last=100fe", got.size(), got[0], got[$]);
        end
        tests++;
        if (got_cyc.size() == 0 || got_cyc[0] != start_cyc + 2) begin
            fails++;
            $display("FAIL first_valid_latency: got %0d, required %0d", got_cyc.size() ? got_cyc[0] - start_cyc : -1, 2);
        end
    endtask

    task automatic test_diagonal;
        int bad = 0;
        rom[500] = ent(22, 50, 1);  rom[501] = ent(0, 0, 3);
        rom[510] = ent(46, 46, 2);  rom[511] = ent(0, 0, 3);
        run_image(500, "diag_pos");
        run_image(510, "diag");
        for (int i = 0; i < got.size(); i++)
            if (int'(got[i][15:8]) != 23 + i || got[i][7:0] > (i == 0 ? 8'd50 : got[i-1][7:0])) bad++;
        tests++;
        if (got.size() != 24 || bad != 0 || got[$] !== {1'b1, 8'd46, 8'd46}) begin
            fails++;
            $display("FAIL diag_shape: got n=%0d bad=%0d last=%h, required n=24 bad=0 last=12e2e", got.size(), bad, got[$]);
        end
        diag_q = got;
    endtask

    task automatic test_back_to_back;
        run_image(500, "bp_pos");
        bp_mode = 1;
        run_image(510, "bp");
        bp_mode = 0;
        tests++;
        if (got != diag_q) begin
            fails++;
            $display("FAIL bp_sequence: got %0d points, required the %0d unstalled points", got.size(), diag_q.size());
        end
    endtask

    task automatic test_invalid;
        int d;
        rom[200] = ent(5, 5, 1);  rom[201] = ent(9, 7, 2);  rom[202] = ent(3, 3, 2);
        rom[203] = ent(100, 100, 1);  rom[204] = ent(100, 100, 2);  rom[205] = 18'h0;
        model_run(200);
        watch_addr = 205;  fetch_cyc = -1;
        pulse_start(200, 1);
        wait_done(5000, d);
        watch_addr = -1;
        check_run("invalid");
        tests++;
        if (d != fetch_cyc + 1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL invalid_timing: got done at fetch+%0d busy=%b, required fetch+1 busy=0", d - fetch_cyc, busy);
        end
    endtask

    task automatic test_reset_mid;
        int d;
        pulse_start(0, 1);
        repeat (300) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        tests++;
        if ({rom_addr, x_out, y_out, beam_on, pt_valid, busy, done, err} !== '0) begin
            fails++;
            $display("FAIL midreset_state: got %h, required 0", {rom_addr, x_out, y_out, beam_on, pt_valid, busy, done, err});
        end
        rst_n = 1'b1;
        mx = 0;  my = 0;
        repeat (3) @(negedge clk);
        tests++;
        if (done_cnt != 0) begin
            fails++;
            $display("FAIL midreset_done: got %0d done pulses, required 0", done_cnt);
        end
        run_image(510, "after_reset");
    endtask

    task automatic test_corners;
        int d;
        rom[100] = ent(9, 9, 3);
        pulse_start(100, 1);
        tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL end_first_c1: got busy=%b done=%b, required busy=1 done=0", busy, done);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0 || got.size() != 0) begin
            fails++;
            $display("FAIL end_first_c2: got done=%b err=%b busy=%b n=%0d, required 1 0 0 0", done, err, busy, got.size());
        end
        // Zero-length draw after a move to the same point.
        rom[400] = ent(77, 33, 1);  rom[401] = ent(77, 33, 2);  rom[402] = ent(0, 0, 3);
        run_image(400, "zero_len");
        tests++;
        if (got.size() != 2 || got[1] !== {1'b1, 8'd77, 8'd33}) begin
            fails++;
            $display("FAIL zero_len_point: got n=%0d last=%h, required n=2 last=14d21", got.size(), got[$]);
        end
        // Settle gap: move transfer, 4 idle, fetch, then the first lit point.
        rom[300] = ent(10, 10, 1);  rom[301] = ent(13, 11, 2);  rom[302] = ent(0, 0, 3);
        run_image(300, "settle");
        tests++;
        if (got_cyc.size() < 2 || got_cyc[1] - got_cyc[0] != 6) begin
            fails++;
            $display("FAIL settle_gap: got %0d, required 6", got_cyc.size() < 2 ? -1 : got_cyc[1] - got_cyc[0]);
        end
        // start while busy is ignored, and so is a start coincident with done.
        model_run(0);
        pulse_start(0, 1);
        repeat (50) @(negedge clk);
        pulse_start(100, 0);
        wait_done(5000, d);
        check_run("start_busy");
        start = 1'b1;  start_addr = 16'd100;
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL start_at_done: got busy=%b, required 0", busy);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL start_at_done_pulse: got done=%b, required 0", done);
        end
        // Top-of-ROM exhaustion.
        rom[65534] = ent(1, 2, 1);  rom[65535] = ent(4, 9, 2);
        run_image(65534, "exhaust");
    endtask

    task automatic test_random;
        int base, n;
        for (int k = 0; k < 3; k++) begin
            base = 1000 + k * 20;
            n = $urandom_range(3, 7);
            for (int i = 0; i < n; i++)
                rom[base + i] = ent($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(1, 2));
            rom[base + n] = ent(0, 0, 3);
            bp_mode = k[0];
            run_image(base, "random");
        end
        bp_mode = 0;
    endtask

    initial begin
        rst_n = 1'b0;  start = 1'b0;  start_addr = '0;  watch_addr = -1;  fetch_cyc = -1;
        for (int i = 0; i < 65536; i++) rom[i] = '0;
        test_reset;
        test_frame;
        test_diagonal;
        test_back_to_back;
        test_invalid;
        test_reset_mid;
        test_corners;
        test_random;
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
